// File: rtl/dp_negabs_pkg.sv
// Shared definitions for the negate/absolute-value datapath.
// Holds the operation codes and the group-level carry lookahead.
package dp_negabs_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS = 2'd0;
    localparam mode_t MODE_ONES = 2'd1;
    localparam mode_t MODE_NEG  = 2'd2;
    localparam mode_t MODE_ABS  = 2'd3;

    // Upper bound on WIDTH/GROUP; the top level refuses to elaborate beyond it.
    localparam int MAX_GROUPS = 64;

    // Carry-in for group `grp` is set when any bit of any lower group is set.
    function automatic logic group_carry_in(input logic [MAX_GROUPS-1:0] any_set,
                                            input int grp);
        logic carry;
        carry = 1'b0;
        for (int i = 0; i < MAX_GROUPS; i++) begin
            if (i < grp) begin
                carry = carry | any_set[i];
            end
        end
        return carry;
    endfunction

endpackage

// File: rtl/dp_negabs_pipe_if.sv
// Operand-in / result-out handshake bundle for dp_negabs_pipe.
// The datapath uses the slave view; whoever feeds and drains it uses the master view.
interface dp_negabs_pipe_if #(
    parameter int WIDTH = 32
) ();
    import dp_negabs_pkg::*;

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    mode_t            IN_MODE;

    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_ZERO;
    logic             OUT_OVF;
    logic             OUT_SIGN;

    modport slave (
        input  IN_VALID, IN_DATA, IN_MODE, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_ZERO, OUT_OVF, OUT_SIGN
    );

    modport master (
        output IN_VALID, IN_DATA, IN_MODE, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_ZERO, OUT_OVF, OUT_SIGN
    );

endinterface

// File: rtl/dp_negabs_group.sv
// One GROUP-wide slice of the copy-until-first-one negator.
// The carry ripples inside the slice; the slice reports whether any of its bits is set.
module dp_negabs_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] grp_in,
    input  logic             carry_in,
    input  logic             invert_en,
    output logic [GROUP-1:0] grp_out,
    output logic             any_set
);

    logic carry;

    // Bit i flips only when some lower bit (in this group or below) is already set.
    always_comb begin
        carry   = carry_in;
        grp_out = '0;
        for (int i = 0; i < GROUP; i++) begin
            grp_out[i] = grp_in[i] ^ (invert_en & carry);
            carry      = carry | grp_in[i];
        end
        any_set = |grp_in;
    end

endmodule

// File: rtl/dp_negabs_pipe.sv
// Pipelined pass / complement / negate / absolute-value unit with valid/ready on both sides.
// Group carry-ins are formed up front; the in-group ripple and flags are formed in the last stage.
module dp_negabs_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input logic             CLK,
    input logic             RST,
    dp_negabs_pipe_if.slave bus
);
    import dp_negabs_pkg::*;

    localparam int NGROUPS = (GROUP > 0) ? (WIDTH / GROUP) : 1;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_width
        $error("dp_negabs_pipe: WIDTH must be >= 2 and a multiple of GROUP");
    end
    if (NGROUPS > MAX_GROUPS) begin : g_bad_groups
        $error("dp_negabs_pipe: WIDTH/GROUP exceeds MAX_GROUPS");
    end
    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("dp_negabs_pipe: STAGES must be 1 or 2");
    end

    logic [MAX_GROUPS-1:0] in_any_ext;
    logic [NGROUPS-1:0]    in_cin;

    always_comb begin
        in_any_ext = '0;
        in_cin     = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            in_any_ext[g] = |bus.IN_DATA[g*GROUP +: GROUP];
        end
        for (int g = 0; g < NGROUPS; g++) begin
            in_cin[g] = group_carry_in(in_any_ext, g);
        end
    end

    logic [WIDTH-1:0]   x2;
    mode_t              mode2;
    logic [NGROUPS-1:0] cin2;
    logic               src_valid;
    logic               in_ready;
    logic               out_advance;

    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_zero_r;
    logic               out_ovf_r;
    logic               out_sign_r;

    // The output register may load when it is empty or being drained this cycle.
    assign out_advance = ~out_valid_r | bus.OUT_READY;

    if (STAGES == 2) begin : g_two_stage
        logic               s1_valid;
        logic [WIDTH-1:0]   s1_x;
        mode_t              s1_mode;
        logic [NGROUPS-1:0] s1_cin;

        always_ff @(posedge CLK) begin
            if (RST) begin
                s1_valid <= 1'b0;
                s1_x     <= '0;
                s1_mode  <= MODE_PASS;
                s1_cin   <= '0;
            end else if (in_ready) begin
                s1_valid <= bus.IN_VALID;
                if (bus.IN_VALID) begin
                    s1_x    <= bus.IN_DATA;
                    s1_mode <= bus.IN_MODE;
                    s1_cin  <= in_cin;
                end
            end
        end

        assign in_ready  = ~s1_valid | out_advance;
        assign src_valid = s1_valid;
        assign x2        = s1_x;
        assign mode2     = s1_mode;
        assign cin2      = s1_cin;
    end else begin : g_one_stage
        assign in_ready  = out_advance;
        assign src_valid = bus.IN_VALID;
        assign x2        = bus.IN_DATA;
        assign mode2     = bus.IN_MODE;
        assign cin2      = in_cin;
    end

    logic               neg_apply;
    logic [WIDTH-1:0]   grp_y;
    logic [NGROUPS-1:0] grp_any;

    assign neg_apply = (mode2 == MODE_NEG) | ((mode2 == MODE_ABS) & x2[WIDTH-1]);

    for (genvar g = 0; g < NGROUPS; g++) begin : g_group
        dp_negabs_group #(
            .GROUP(GROUP)
        ) u_group (
            .grp_in   (x2[g*GROUP +: GROUP]),
            .carry_in (cin2[g]),
            .invert_en(neg_apply),
            .grp_out  (grp_y[g*GROUP +: GROUP]),
            .any_set  (grp_any[g])
        );
    end

    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             y_ovf;
    logic             y_sign;

    // Outside ONES mode the result is zero exactly when the operand is zero.
    always_comb begin
        y      = (mode2 == MODE_ONES) ? ~x2 : grp_y;
        y_zero = (mode2 == MODE_ONES) ? (&x2) : ~(|grp_any);
        y_ovf  = neg_apply & (x2 == MSB_ONLY);
        y_sign = y[WIDTH-1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_zero_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_sign_r  <= 1'b0;
        end else if (out_advance) begin
            out_valid_r <= src_valid;
            if (src_valid) begin
                out_data_r <= y;
                out_zero_r <= y_zero;
                out_ovf_r  <= y_ovf;
                out_sign_r <= y_sign;
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_r;
    assign bus.OUT_DATA  = out_data_r;
    assign bus.OUT_ZERO  = out_zero_r;
    assign bus.OUT_OVF   = out_ovf_r;
    assign bus.OUT_SIGN  = out_sign_r;

endmodule

// File: doc/dp_negabs_pipe.md
Name: dp_negabs_pipe

Overview:
- Parametrised, pipelined datapath unit for conditional complement, negate and absolute value on a WIDTH-bit operand.
- Negation uses the copy-until-first-one rule: result bit i = in[i] XOR (any lower bit set).
- The "any lower bit set" term comes from a GROUP-wide lookahead chain, not a ripple chain.
- Sits in the ALU operand path, fed and drained by valid/ready handshakes.
- Adds to the single-bit complement/lookahead cell: multi-bit width, mode select, status flags, a 1- or 2-stage pipeline and backpressure.

Parameters:
- WIDTH, 32, operand and result width; must be >=2 and a multiple of GROUP (elaboration error otherwise).
- GROUP, 4, bits per lookahead group.
- STAGES, 2, pipeline depth; legal values are 1 and 2 (anything else is an elaboration error).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  input operand valid.
- IN_READY  out  1  unit can accept an operand this cycle.
- IN_DATA  in  WIDTH  operand.
- IN_MODE  in  2  0=PASS, 1=ONES, 2=NEG, 3=ABS.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- OUT_DATA  out  WIDTH  result.
- OUT_ZERO  out  1  result is all zeros.
- OUT_OVF  out  1  NEG or ABS applied to the most-negative value (1 followed by zeros).
- OUT_SIGN  out  1  result MSB.

Behaviour:
- Reset:
  - While RST=1 at a clock edge, all stage valid bits clear and all data/flag registers load 0.
  - OUT_VALID=0, OUT_DATA=0, flags=0 in the cycle after reset.
  - IN_READY=1 once RST is low.
  - Reset mid-operation discards all in-flight operands; nothing is emitted for them.
- Handshake:
  - A transfer occurs when VALID & READY are both 1 at a rising edge.
  - OUT_DATA and flags hold stable while OUT_VALID=1 and OUT_READY=0.
  - IN_DATA/IN_MODE are sampled only on accept.
  - IN_VALID is ignored when IN_READY=0.
- Stage advance rule: a stage may load when it is empty or when its contents move on in the same cycle.
  - OUT_READY propagates combinationally to IN_READY: IN_READY = ~s1_valid | (s1 advancing).
  - Full throughput is 1 operand/cycle with no bubbles under continuous OUT_READY=1.
- Latency: an operand accepted at edge k gives OUT_VALID=1 after edge k+STAGES-1, i.e. valid in the cycle following the last register load.
- Function (per operand):
  - PASS: y = x.
  - ONES: y = ~x.
  - NEG: y[i] = x[i] ^ c[i], with c[0]=0 and c[i] = OR(x[i-1:0]).
  - ABS: as NEG when x[WIDTH-1]=1, else PASS.
- Lookahead:
  - Each group produces group-any-set = OR of its bits.
  - Group carry-in = OR of the group-any-set values of all lower groups.
  - Within a group the carry ripples bit-to-bit.
- STAGES=2 split:
  - Stage 1 registers x, mode and the per-group carry-ins (WIDTH/GROUP bits).
  - Stage 2 computes the in-group ripple, the XOR and the flags, then registers them.
- STAGES=1: the whole computation is combinational into the output register.
- Flags:
  - OUT_ZERO = (y==0).
  - OUT_OVF = (mode is NEG, or ABS with x MSB set) & (x == 1<<(WIDTH-1)); y then equals x.
  - OUT_SIGN = y[WIDTH-1].
- Boundaries:
  - NEG of 0 gives 0 with ZERO=1 and OVF=0.
  - ABS of most-negative gives OVF=1 and SIGN=1.
  - Simultaneous output drain and input accept while full is legal and loses no data.

Decomposition:
- Package dp_negabs_pkg holds:
  - mode constants MODE_PASS/MODE_ONES/MODE_NEG/MODE_ABS (2-bit);
  - the function computing group carry-ins from group-any-set bits.
- Sub-module dp_negabs_group holds one GROUP-wide slice.
  - Inputs: group bits, carry-in, invert-enable.
  - Outputs: group result, group-any-set.
- The top level handles WIDTH/GROUP instantiation, pipeline registers, handshake and flags.

Test Plan:
- WIDTH=8, GROUP=4, STAGES=2, OUT_READY=1:
  - NEG 0x01 -> 0xFF, SIGN=1.
  - NEG 0x28 -> 0xD8.
  - Each result appears 2 cycles after accept.
- WIDTH=8: ABS 0xF6 -> 0x0A. ABS 0x35 -> 0x35. ABS 0x80 -> 0x80 with OVF=1, SIGN=1.
- WIDTH=8:
  - NEG 0x00 -> 0x00, ZERO=1, OVF=0.
  - ONES 0x5A -> 0xA5.
  - PASS 0x10 -> 0x10 (a group carry crosses the group boundary with none set below).
- Backpressure: stream 4 NEG operands, hold OUT_READY=0 for 3 cycles.
  - IN_READY drops once both stages are full.
  - OUT_DATA stays stable.
  - After release, all 4 results appear in order with no loss or duplication.
- Reset: assert RST for 1 cycle with both stages full.
  - Next cycle OUT_VALID=0, OUT_DATA=0, IN_READY=1.
  - No stale result is ever emitted.
- Sweep STAGES=1 and WIDTH=32/GROUP=8 with random operands and modes against a reference model.
  - Latency is 1 cycle for STAGES=1.
  - All results and flags match the model.
